dsp48a1_slice: RTL and testbench

Spartan-6 style DSP slice: 18-bit pre-adder/subtracter, 18x18 unsigned multiplier, 48-bit post-adder/subtracter with X/Z operand muxes, carry logic and cascade outputs. Each pipeline stage can be registered or bypassed by parameter. Sits in the datapath as the arithmetic primitive; slices chain through BCOUT/PCOUT.

---
 rtl/dsp48a1_pkg.sv | 30 +++
 rtl/dsp_pipe_reg.sv | 44 ++++
 rtl/dsp48a1_slice.sv | 149 ++++++++++++++
 tb/tb_dsp48a1_slice.sv | 127 ++++++++++++
 4 files changed

// File: rtl/dsp48a1_pkg.sv
// Shared widths, OPMODE bit positions and X/Z mux encodings for the DSP48A1 slice.
package dsp48a1_pkg;

  localparam int unsigned OpW  = 18;  // pre-adder / multiplier operand width
  localparam int unsigned MulW = 36;  // multiplier product width
  localparam int unsigned PW   = 48;  // post-adder / P width

  // OPMODE bit indices
  localparam int unsigned OpXLo      = 0;
  localparam int unsigned OpZLo      = 2;
  localparam int unsigned OpPreAdd   = 4;
  localparam int unsigned OpCarry    = 5;
  localparam int unsigned OpPreSub   = 6;
  localparam int unsigned OpPostSub  = 7;

  typedef enum logic [1:0] {
    XZero = 2'b00,
    XMul  = 2'b01,
    XP    = 2'b10,
    XDab  = 2'b11
  } x_sel_e;

  typedef enum logic [1:0] {
    ZZero = 2'b00,
    ZPcin = 2'b01,
    ZP    = 2'b10,
    ZC    = 2'b11
  } z_sel_e;

endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: sync reset beats clock enable, async active-low reset clears.
// Reg = 0 turns the stage into a wire.
module dsp_pipe_reg #(
  parameter int unsigned Width = 18,
  parameter bit          Reg   = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             rst_i,
  input  logic             ce_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Reg) begin : g_reg
    logic [Width-1:0] q_d, q_q;

    // Next state: sync reset, then load on enable, else hold.
    always_comb begin
      q_d = q_q;
      if (rst_i) begin
        q_d = '0;
      end else if (ce_i) begin
        q_d = d_i;
      end
    end

    // State register with asynchronous clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        q_q <= '0;
      end else begin
        q_q <= q_d;
      end
    end

    assign q_o = q_q;
  end else begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, rst_i, ce_i};
    assign q_o = d_i;
  end

endmodule

// File: rtl/dsp48a1_slice.sv
// Spartan-6 style DSP slice: pre-adder, 18x18 multiplier, 48-bit post-adder with cascades.
// Optional macro DSP48A1_BCIN_CASCADE_EN enables B_INPUT = "CASCADE" (BCIN into the B path).
module dsp48a1_slice
  import dsp48a1_pkg::*;
#(
  parameter bit    A0REG       = 1'b0,
  parameter bit    B0REG       = 1'b0,
  parameter bit    A1REG       = 1'b1,
  parameter bit    B1REG       = 1'b1,
  parameter bit    CREG        = 1'b1,
  parameter bit    DREG        = 1'b1,
  parameter bit    MREG        = 1'b1,
  parameter bit    PREG        = 1'b1,
  parameter bit    CARRYINREG  = 1'b1,
  parameter bit    CARRYOUTREG = 1'b1,
  parameter bit    OPMODEREG   = 1'b1,
  parameter string CARRYINSEL  = "OPMODE5",
  parameter string B_INPUT     = "DIRECT"
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic [OpW-1:0]  A,
  input  logic [OpW-1:0]  B,
  input  logic [OpW-1:0]  D,
  input  logic [PW-1:0]   C,
  input  logic [OpW-1:0]  BCIN,
  input  logic [PW-1:0]   PCIN,
  input  logic            CARRYIN,
  input  logic [7:0]      OPMODE,
  input  logic            RSTA,
  input  logic            RSTB,
  input  logic            RSTC,
  input  logic            RSTD,
  input  logic            RSTM,
  input  logic            RSTP,
  input  logic            RSTCARRYIN,
  input  logic            RSTOPMODE,
  input  logic            CEA,
  input  logic            CEB,
  input  logic            CEC,
  input  logic            CED,
  input  logic            CEM,
  input  logic            CEP,
  input  logic            CECARRYIN,
  input  logic            CEOPMODE,
  output logic [OpW-1:0]  BCOUT,
  output logic [MulW-1:0] M,
  output logic [PW-1:0]   P,
  output logic [PW-1:0]   PCOUT,
  output logic            CARRYOUT,
  output logic            CARRYOUTF
);

  logic [OpW-1:0]  b_src, a0, b0, d_r, a1, b1, b1_d;
  logic [PW-1:0]   c_r, x_mux, z_mux, p_r;
  logic [7:0]      op_r;
  logic [MulW-1:0] m_d, m_r;
  logic            cyi_d, cyi_r, cyo_d, cyo_r;
  logic [PW:0]     post_res;

`ifdef DSP48A1_BCIN_CASCADE_EN
  assign b_src = (B_INPUT == "CASCADE") ? BCIN : B;
`else
  logic unused_bcin;
  localparam bit BInputCascade = (B_INPUT == "CASCADE");
  assign unused_bcin = ^{BCIN, BInputCascade};
  assign b_src = B;
`endif

  // Stage 0: input operands and OPMODE.
  dsp_pipe_reg #(.Width(OpW), .Reg(A0REG)) u_a0 (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTA), .ce_i(CEA), .d_i(A), .q_o(a0));
  dsp_pipe_reg #(.Width(OpW), .Reg(B0REG)) u_b0 (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTB), .ce_i(CEB), .d_i(b_src), .q_o(b0));
  dsp_pipe_reg #(.Width(OpW), .Reg(DREG)) u_d (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTD), .ce_i(CED), .d_i(D), .q_o(d_r));
  dsp_pipe_reg #(.Width(PW), .Reg(CREG)) u_c (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTC), .ce_i(CEC), .d_i(C), .q_o(c_r));
  dsp_pipe_reg #(.Width(8), .Reg(OPMODEREG)) u_op (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTOPMODE), .ce_i(CEOPMODE), .d_i(OPMODE), .q_o(op_r));

  // Pre-adder/subtracter feeding B1, 18-bit wrap.
  always_comb begin
    b1_d = b0;
    if (op_r[OpPreAdd]) begin
      b1_d = op_r[OpPreSub] ? (d_r - b0) : (d_r + b0);
    end
  end

  // Stage 1: A1/B1 and the carry-in register.
  dsp_pipe_reg #(.Width(OpW), .Reg(A1REG)) u_a1 (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTA), .ce_i(CEA), .d_i(a0), .q_o(a1));
  dsp_pipe_reg #(.Width(OpW), .Reg(B1REG)) u_b1 (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTB), .ce_i(CEB), .d_i(b1_d), .q_o(b1));

  assign cyi_d = (CARRYINSEL == "CARRYIN") ? CARRYIN : op_r[OpCarry];

  dsp_pipe_reg #(.Width(1), .Reg(CARRYINREG)) u_cyi (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTCARRYIN), .ce_i(CECARRYIN), .d_i(cyi_d),
    .q_o(cyi_r));

  // Unsigned 18x18 multiply.
  assign m_d = MulW'(a1) * MulW'(b1);

  dsp_pipe_reg #(.Width(MulW), .Reg(MREG)) u_m (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTM), .ce_i(CEM), .d_i(m_d), .q_o(m_r));

  // X/Z operand muxes and 49-bit post-adder; bit 48 is carry or borrow.
  always_comb begin
    x_mux = '0;
    z_mux = '0;
    unique case (x_sel_e'(op_r[OpXLo +: 2]))
      XZero:   x_mux = '0;
      XMul:    x_mux = PW'(m_r);
      XP:      x_mux = p_r;
      XDab:    x_mux = {d_r[11:0], a1, b1};
      default: x_mux = '0;
    endcase
    unique case (z_sel_e'(op_r[OpZLo +: 2]))
      ZZero:   z_mux = '0;
      ZPcin:   z_mux = PCIN;
      ZP:      z_mux = p_r;
      ZC:      z_mux = c_r;
      default: z_mux = '0;
    endcase
    if (op_r[OpPostSub]) begin
      post_res = {1'b0, z_mux} - ({1'b0, x_mux} + (PW + 1)'(cyi_r));
    end else begin
      post_res = {1'b0, z_mux} + {1'b0, x_mux} + (PW + 1)'(cyi_r);
    end
  end

  assign cyo_d = post_res[PW];

  dsp_pipe_reg #(.Width(PW), .Reg(PREG)) u_p (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTP), .ce_i(CEP), .d_i(post_res[PW-1:0]),
    .q_o(p_r));
  dsp_pipe_reg #(.Width(1), .Reg(CARRYOUTREG)) u_cyo (
    .clk_i(CLK), .rst_ni(RST_N), .rst_i(RSTCARRYIN), .ce_i(CECARRYIN), .d_i(cyo_d),
    .q_o(cyo_r));

  assign BCOUT     = b1;
  assign M         = m_r;
  assign P         = p_r;
  assign PCOUT     = p_r;
  assign CARRYOUT  = cyo_r;
  assign CARRYOUTF = cyo_r;

endmodule

// File: tb/tb_dsp48a1_slice.sv
// Directed self-checking bench for dsp48a1_slice with default parameters.
module tb_dsp48a1_slice;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b1;
  logic [17:0] A = '0, B = '0, D = '0, BCIN = '0;
  logic [47:0] C = '0, PCIN = '0;
  logic        CARRYIN = 1'b0;
  logic [7:0]  OPMODE = '0;
  logic        RSTA = 0, RSTB = 0, RSTC = 0, RSTD = 0, RSTM = 0, RSTP = 0;
  logic        RSTCARRYIN = 0, RSTOPMODE = 0;
  logic        CEA = 0, CEB = 0, CEC = 0, CED = 0, CEM = 0, CEP = 0;
  logic        CECARRYIN = 0, CEOPMODE = 0;
  logic [17:0] BCOUT;
  logic [35:0] M;
  logic [47:0] P, PCOUT;
  logic        CARRYOUT, CARRYOUTF;

  int n_assert = 0;
  int n_fail   = 0;

  dsp48a1_slice dut (
    .CLK(CLK), .RST_N(RST_N), .A(A), .B(B), .D(D), .C(C), .BCIN(BCIN), .PCIN(PCIN),
    .CARRYIN(CARRYIN), .OPMODE(OPMODE),
    .RSTA(RSTA), .RSTB(RSTB), .RSTC(RSTC), .RSTD(RSTD), .RSTM(RSTM), .RSTP(RSTP),
    .RSTCARRYIN(RSTCARRYIN), .RSTOPMODE(RSTOPMODE),
    .CEA(CEA), .CEB(CEB), .CEC(CEC), .CED(CED), .CEM(CEM), .CEP(CEP),
    .CECARRYIN(CECARRYIN), .CEOPMODE(CEOPMODE),
    .BCOUT(BCOUT), .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT), .CARRYOUTF(CARRYOUTF)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [17:0] e_bc, input logic [35:0] e_m,
                           input logic [47:0] e_p, input logic e_co);
    check({tag, " BCOUT"}, 48'(BCOUT), 48'(e_bc));
    check({tag, " M"}, 48'(M), 48'(e_m));
    check({tag, " P"}, P, e_p);
    check({tag, " PCOUT"}, PCOUT, e_p);
    check({tag, " CARRYOUT"}, 48'(CARRYOUT), 48'(e_co));
    check({tag, " CARRYOUTF"}, 48'(CARRYOUTF), 48'(e_co));
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic set_rst(input logic v);
    {RSTA, RSTB, RSTC, RSTD, RSTM, RSTP, RSTCARRYIN, RSTOPMODE} = {8{v}};
  endtask

  task automatic set_ce(input logic v);
    {CEA, CEB, CEC, CED, CEM, CEP, CECARRYIN, CEOPMODE} = {8{v}};
  endtask

  initial begin
    // Asynchronous reset at start.
    #1 RST_N = 1'b0;
    #2;
    check_all("async_reset", 18'h0, 36'h0, 48'h0, 1'b0);
    RST_N = 1'b1;
    tick(1);

    // All sync resets asserted with random data and enables.
    set_rst(1'b1);
    set_ce(1'b1);
    A = 18'($urandom); B = 18'($urandom); D = 18'($urandom);
    C = {16'($urandom), 32'($urandom)}; PCIN = {16'($urandom), 32'($urandom)};
    BCIN = 18'($urandom); OPMODE = 8'($urandom); CARRYIN = 1'b1;
    tick(1);
    check_all("sync_reset", 18'h0, 36'h0, 48'h0, 1'b0);

    // C - (D-B)*A: B1 = 15, M = 300, P = 350 - 300.
    set_rst(1'b0);
    CARRYIN = 1'b0; BCIN = '0; PCIN = '0;
    OPMODE = 8'hDD; A = 18'd20; B = 18'd10; D = 18'd25; C = 48'd350;
    tick(4);
    check_all("op_dd", 18'h0F, 36'h12C, 48'h32, 1'b0);

    // Pre-add only, X = Z = 0.
    OPMODE = 8'h10;
    tick(3);
    check_all("op_10", 18'h23, 36'h2BC, 48'h0, 1'b0);

    // P + P feedback from zero stays zero.
    OPMODE = 8'h0A;
    tick(6);
    check_all("op_0a", 18'h0A, 36'hC8, 48'h0, 1'b0);

    // PCIN - ({D[11:0],A,B} + 1) with borrow.
    OPMODE = 8'hA7; A = 18'd5; B = 18'd6; D = 18'd25; PCIN = 48'd3000;
    tick(3);
    check_all("op_a7", 18'h06, 36'h1E, 48'hFE6F_FFEC_0BB1, 1'b1);

    // P held while CEP is low.
    CEP = 1'b0;
    PCIN = 48'd1000;
    tick(3);
    check("cep_hold P", P, 48'hFE6F_FFEC_0BB1);
    check("cep_hold PCOUT", PCOUT, 48'hFE6F_FFEC_0BB1);
    CEP = 1'b1;
    tick(1);
    check("cep_resume P", P, 48'hFE6F_FFEC_03E1);
    check("cep_resume CARRYOUT", 48'(CARRYOUT), 48'h1);

    // Mid-run asynchronous reset clears outputs without a clock edge.
    RST_N = 1'b0;
    #1;
    check_all("midrun_reset", 18'h0, 36'h0, 48'h0, 1'b0);
    RST_N = 1'b1;
    tick(1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
